// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo
// First-word-fall-through AXI-Stream FIFO that frames a TLAST-less stream
// into packets for a DMA engine.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   cfg_pkt_len      beats per packet; 0 behaves as 1, larger than
//                    MAX_PKT_LEN behaves as MAX_PKT_LEN
//   s_axis_*         upstream slave stream (tvalid, tdata, tready)
//   m_axis_*         downstream master stream (tvalid, tdata, tlast, tready)
//   level            entries stored, 0..DEPTH
//   almost_full      level >= AFULL_THRESH
//   pkt_done         one-cycle pulse after a TLAST beat is accepted downstream
//
// Handshake: a beat transfers on a rising edge where valid && ready. Valid
// never depends on ready. Once TLAST is shown on a beat it stays asserted
// until that beat is accepted.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int MAX_PKT_LEN  = 1024,
    parameter int TLAST_MODE   = 0,
    parameter int AFULL_THRESH = DEPTH - 2,
    localparam int LEN_W       = $clog2(MAX_PKT_LEN + 1),
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_W-1:0]      cfg_pkt_len,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [PTR_W:0]        level,
    output logic                  almost_full,
    output logic                  pkt_done
);

    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PKT_LEN);
    localparam logic [PTR_W:0]   LEVEL_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   AFULL_LVL = (PTR_W + 1)'(AFULL_THRESH);
    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  tlast_hold_q, tlast_hold_d;
    logic                  pkt_done_q, pkt_done_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  full;
    logic                  empty;
    logic                  in_hs;
    logic                  out_hs;
    logic [LEN_W-1:0]      cfg_eff;
    logic [LEN_W-1:0]      eff_len;
    logic                  len_last;
    logic                  drain_last;

    // Status is a function of the registered pointers only.
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign full          = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                           (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign level         = wr_ptr_q - rd_ptr_q;
    assign almost_full   = (level >= AFULL_LVL);
    assign s_axis_tready = !full;
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign pkt_done      = pkt_done_q;

    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    assign cfg_eff = (cfg_pkt_len == '0)     ? LEN_ONE :
                     (cfg_pkt_len > LEN_MAX) ? LEN_MAX : cfg_pkt_len;

    // At a packet boundary the live configuration applies; mid-packet the
    // length captured at the boundary is used.
    assign eff_len  = (beat_cnt_q == '0) ? cfg_eff : len_q;
    assign len_last = (beat_cnt_q == eff_len - LEN_ONE);

    // Drain framing: the sole buffered beat closes the packet unless another
    // beat is arriving on this edge. This is the only path from an input
    // (s_axis_tvalid) to an output (m_axis_tlast).
    assign drain_last = (TLAST_MODE == 1) && (level == LEVEL_ONE) && !in_hs;

    assign m_axis_tlast = m_axis_tvalid && (len_last || drain_last || tlast_hold_q);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = (beat_cnt_q == '0) ? cfg_eff : len_q;
        tlast_hold_d = tlast_hold_q;
        pkt_done_d   = out_hs && m_axis_tlast;

        if (in_hs) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (out_hs) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            tlast_hold_d = 1'b0;
            beat_cnt_d   = m_axis_tlast ? '0 : beat_cnt_q + LEN_ONE;
        end else if (m_axis_tvalid && m_axis_tlast) begin
            // Keep TLAST up even if the drain condition disappears while stalled.
            tlast_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            len_q        <= LEN_ONE;
            tlast_hold_q <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            tlast_hold_q <= tlast_hold_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    // Storage is not reset; it is only ever read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: two instances (length-only and length-or-drain
// framing) share the same stimulus and are checked against a queue-based
// reference model, a vector table and hand-written corner sequences.
module tb_axis_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int MAXL  = 1024;
    localparam int LEN_W = $clog2(MAXL + 1);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int AFULL = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [LEN_W-1:0] cfg = '0;
    logic             s_valid = 1'b0;
    logic [DW-1:0]    s_data = '0;
    logic             m_ready = 1'b0;

    logic             s_ready0, m_valid0, m_last0, afull0, pd0;
    logic [DW-1:0]    m_data0;
    logic [LVL_W-1:0] level0;
    logic             s_ready1, m_valid1, m_last1, afull1, pd1;
    logic [DW-1:0]    m_data1;
    logic [LVL_W-1:0] level1;

    axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PKT_LEN(MAXL),
                    .TLAST_MODE(0), .AFULL_THRESH(AFULL)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_pkt_len(cfg),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tready(s_ready0),
        .m_axis_tvalid(m_valid0), .m_axis_tdata(m_data0), .m_axis_tlast(m_last0),
        .m_axis_tready(m_ready), .level(level0), .almost_full(afull0), .pkt_done(pd0));

    axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_PKT_LEN(MAXL),
                    .TLAST_MODE(1), .AFULL_THRESH(AFULL)) dut1 (
        .clk(clk), .rst_n(rst_n), .cfg_pkt_len(cfg),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tready(s_ready1),
        .m_axis_tvalid(m_valid1), .m_axis_tdata(m_data1), .m_axis_tlast(m_last1),
        .m_axis_tready(m_ready), .level(level1), .almost_full(afull1), .pkt_done(pd1));

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q[$];     // beats buffered, head = next output
    int            bc[2];        // beats accepted so far in current packet
    int            lenm[2];      // packet length latched at packet start
    bit            hold[2];      // TLAST already shown on a stalled beat
    bit            pdm[2];       // expected pkt_done

    bit            out_log[$];   // tlast of each beat accepted from dut0
    bit            last_in_hs;
    int            next_val;

    logic             snap_valid0, snap_last0, snap_ready0, snap_pd0;
    logic             snap_last1;
    logic [DW-1:0]    snap_data0, snap_data1;
    logic [LVL_W-1:0] snap_level0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int c);
        if (c == 0) return 1;
        if (c > MAXL) return MAXL;
        return c;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int m = 0; m < 2; m++) begin
            bc[m] = 0; lenm[m] = 1; hold[m] = 1'b0; pdm[m] = 1'b0;
        end
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance
    // the model at posedge, return 1 ns after the edge.
    task automatic step();
        int sz, eff;
        bit in_hs, out_hs;
        bit el[2];
        @(negedge clk);
        sz     = exp_q.size();
        in_hs  = s_valid && (sz < DEPTH);
        out_hs = (sz > 0) && m_ready;
        for (int m = 0; m < 2; m++) begin
            eff   = (bc[m] == 0) ? clamp_len(int'(cfg)) : lenm[m];
            el[m] = (sz > 0) && ((bc[m] == eff - 1) ||
                                 (m == 1 && sz == 1 && !in_hs) || hold[m]);
        end
        chk("s_ready0", 32'(s_ready0), 32'(sz < DEPTH));
        chk("m_valid0", 32'(m_valid0), 32'(sz > 0));
        chk("level0",   32'(level0),   sz);
        chk("afull0",   32'(afull0),   32'(sz >= AFULL));
        chk("m_last0",  32'(m_last0),  32'(el[0]));
        chk("pkt_done0", 32'(pd0),     32'(pdm[0]));
        chk("s_ready1", 32'(s_ready1), 32'(sz < DEPTH));
        chk("m_valid1", 32'(m_valid1), 32'(sz > 0));
        chk("level1",   32'(level1),   sz);
        chk("m_last1",  32'(m_last1),  32'(el[1]));
        chk("pkt_done1", 32'(pd1),     32'(pdm[1]));
        if (sz > 0) begin
            chk("m_data0", 32'(m_data0), 32'(exp_q[0]));
            chk("m_data1", 32'(m_data1), 32'(exp_q[0]));
        end
        snap_valid0 = m_valid0; snap_last0 = m_last0; snap_ready0 = s_ready0;
        snap_pd0 = pd0; snap_last1 = m_last1; snap_data0 = m_data0;
        snap_data1 = m_data1; snap_level0 = level0;
        if (out_hs) out_log.push_back(m_last0);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            pdm[m] = out_hs && el[m];
            if (bc[m] == 0) lenm[m] = clamp_len(int'(cfg));
            if (out_hs) begin
                hold[m] = 1'b0;
                bc[m]   = el[m] ? 0 : bc[m] + 1;
            end else if (el[m]) begin
                hold[m] = 1'b1;
            end
        end
        if (out_hs) void'(exp_q.pop_front());
        if (in_hs) exp_q.push_back(s_data);
        last_in_hs = in_hs;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit sv, input bit mr);
        s_valid = sv;
        s_data  = DW'(next_val);
        m_ready = mr;
        step();
        if (last_in_hs) next_val++;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid0", 32'(m_valid0), 0);
        chk("rst_s_ready0", 32'(s_ready0), 1);
        chk("rst_level0",   32'(level0),   0);
        chk("rst_m_last0",  32'(m_last0),  0);
        chk("rst_afull0",   32'(afull0),   0);
        chk("rst_pkt_done0", 32'(pd0),     0);
        chk("rst_m_valid1", 32'(m_valid1), 0);
        chk("rst_level1",   32'(level1),   0);
        model_reset();
        rst_n = 1'b1;
        next_val = 0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            cyc(1'b0, 1'b1);
            guard++;
        end
        chk(name, 32'(exp_q.size()), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit            sv;
        bit            mr;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        bit            exp_last;
        int            exp_level;
        bit            exp_pd;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int guard;
        bit pat[$];

        model_reset();
        next_val = 0;
        cfg = LEN_W'(4);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic order: 12 beats, packet length 4, continuous flow.
        for (int t = 0; t < 14; t++) begin
            vecs[t].sv        = (t < 12);
            vecs[t].mr        = 1'b1;
            vecs[t].exp_valid = (t >= 1) && (t <= 12);
            vecs[t].exp_data  = DW'(t - 1);
            vecs[t].exp_last  = vecs[t].exp_valid && (((t - 1) % 4) == 3);
            vecs[t].exp_level = (t == 0 || t == 13) ? 0 : 1;
            vecs[t].exp_pd    = (t == 5) || (t == 9) || (t == 13);
        end
        for (int t = 0; t < 14; t++) begin
            cyc(vecs[t].sv, vecs[t].mr);
            chk("vec_valid", 32'(snap_valid0), 32'(vecs[t].exp_valid));
            if (vecs[t].exp_valid) chk("vec_data", 32'(snap_data0), 32'(vecs[t].exp_data));
            chk("vec_last",  32'(snap_last0),  32'(vecs[t].exp_last));
            chk("vec_level", 32'(snap_level0), vecs[t].exp_level);
            chk("vec_pd",    32'(snap_pd0),    32'(vecs[t].exp_pd));
        end

        // Fill and stall: 10 offers with downstream stalled.
        do_reset();
        begin
            int acc = 0;
            for (int i = 0; i < 10; i++) begin
                cyc(1'b1, 1'b0);
                if (snap_ready0) acc++;
            end
            chk("fill_accepted", acc, 8);
            chk("fill_level", 32'(level0), 8);
            chk("fill_ready", 32'(s_ready0), 0);
        end
        guard = 0;
        while (next_val < 10 && guard < 30) begin
            cyc(1'b1, 1'b1);
            guard++;
        end
        drain("fill_drain");

        // Simultaneous read/write at level 4 across pointer wrap.
        do_reset();
        repeat (4) cyc(1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b1);
        chk("rw_level", 32'(snap_level0), 4);
        drain("rw_drain");

        // Length change mid-packet: 4 -> 2 after beat 1, then 0 (= every beat).
        do_reset();
        cfg = LEN_W'(4);
        out_log.delete();
        guard = 0;
        while (out_log.size() < 8 && guard < 40) begin
            cfg = (out_log.size() >= 2) ? LEN_W'(2) : LEN_W'(4);
            cyc(1'b1, 1'b1);
            guard++;
        end
        pat = '{0, 0, 0, 1, 0, 1, 0, 1};
        chk("lenchg_count", 32'(out_log.size()), 8);
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            chk("lenchg_tlast", 32'(out_log[i]), 32'(pat[i]));
        cfg = '0;
        out_log.delete();
        repeat (6) cyc(1'b1, 1'b1);
        for (int i = 0; i < out_log.size(); i++)
            chk("len0_tlast", 32'(out_log[i]), 1);
        drain("len0_drain");

        // Drain framing with a stall and an upstream write during the stall.
        do_reset();
        cfg = LEN_W'(16);
        repeat (3) cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("drain_last_t3", 32'(snap_last1), 1);
        cyc(1'b1, 1'b0);
        chk("drain_last_t4", 32'(snap_last1), 1);
        cyc(1'b0, 1'b0);
        chk("drain_last_t5", 32'(snap_last1), 1);
        cyc(1'b0, 1'b1);
        chk("drain_last_t6", 32'(snap_last1), 1);
        chk("drain_data_t6", 32'(snap_data1), 2);
        cfg = LEN_W'(1);
        cyc(1'b1, 1'b1);
        chk("drain_newpkt_last", 32'(snap_last1), 1);
        drain("mode1_drain");

        // Async reset mid-packet at level 5, beat count 2.
        do_reset();
        cfg = LEN_W'(8);
        repeat (3) cyc(1'b1, 1'b1);
        repeat (4) cyc(1'b1, 1'b0);
        chk("pre_rst_level", 32'(level0), 5);
        do_reset();
        cfg = LEN_W'(3);
        out_log.delete();
        guard = 0;
        while (out_log.size() < 6 && guard < 30) begin
            cyc(1'b1, 1'b1);
            guard++;
        end
        pat = '{0, 0, 1, 0, 0, 1};
        chk("postrst_count", 32'(out_log.size()), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            chk("postrst_tlast", 32'(out_log[i]), 32'(pat[i]));

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) begin
                case ($urandom_range(0, 7))
                    0: cfg = LEN_W'(0);
                    1: cfg = LEN_W'(1);
                    2: cfg = LEN_W'(2);
                    3: cfg = LEN_W'(3);
                    4: cfg = LEN_W'(5);
                    5: cfg = LEN_W'(7);
                    6: cfg = LEN_W'(1024);
                    default: cfg = LEN_W'(2047);
                endcase
            end
            if ($urandom_range(0, 999) < 3) do_reset();
            next_val = int'($urandom_range(0, 255));
            cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < ((i / 500) % 2 ? 85 : 45));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
